// File: rtl/sha_round_ctrl.sv
// Round sequencer for the SHA compression datapath: block handshake, working-variable load,
// round stepping with schedule stalls, final hash update and digest handshake.
module sha_round_ctrl #(
  parameter int RND_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             blk_first,
  input  logic             blk_last,
  input  logic             w_valid,
  output logic             w_ready,
  output logic [RND_W-1:0] round,
  output logic [1:0]       ft,
  output logic             load_state,
  output logic             load_init,
  output logic             enable,
  output logic             update_hash,
  output logic             hash_valid,
  input  logic             hash_ready,
  output logic             err
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [RND_W-1:0] r_round, w_last_rnd;
  logic [2:0]       r_mode;
  logic             r_first, r_last, r_err;
  logic             w_accept, w_adv;

  // sha224/sha256 run 64 rounds; sha1 and the 64-bit-word modes run 80
  assign w_last_rnd = (r_mode == 3'd1 || r_mode == 3'd2) ? RND_W'(63) : RND_W'(79);

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_adv       = 1'b0;
    blk_ready   = 1'b0;
    w_ready     = 1'b0;
    round       = '0;
    ft          = 2'd0;
    load_state  = 1'b0;
    load_init   = 1'b0;
    enable      = 1'b0;
    update_hash = 1'b0;
    hash_valid  = 1'b0;
    err         = 1'b0;
    // every output is forced low while reset is held
    if (!rst) begin
      round = r_round;
      err   = r_err;
      case (r_state)
        S_IDLE: begin
          blk_ready = 1'b1;
          w_accept  = blk_valid;
          if (blk_valid && mode != 3'd7) w_next = S_LOAD;
        end
        S_LOAD: begin
          load_state = 1'b1;
          load_init  = r_first;
          w_next     = S_ROUND;
        end
        S_ROUND: begin
          w_adv   = w_valid;
          enable  = w_valid;
          w_ready = w_valid;
          if (r_mode == 3'd0) begin
            if (r_round < RND_W'(20))      ft = 2'd0;
            else if (r_round < RND_W'(40)) ft = 2'd1;
            else if (r_round < RND_W'(60)) ft = 2'd2;
            else                           ft = 2'd3;
          end
          if (w_valid && r_round == w_last_rnd) w_next = S_FINAL;
        end
        S_FINAL: begin
          update_hash = 1'b1;
          w_next      = r_last ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          hash_valid = 1'b1;
          if (hash_ready) w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_mode  <= 3'd0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_accept && (mode == 3'd7);
      if (w_accept) begin
        r_mode  <= mode;
        r_first <= blk_first;
        r_last  <= blk_last;
      end
      if (w_adv) r_round <= (r_round == w_last_rnd) ? '0 : r_round + RND_W'(1);
    end
  end
endmodule

// File: tb/tb_sha_round_ctrl.sv
// Scoreboard bench for sha_round_ctrl: each accepted block expands into its expected event
// list (load, rounds, update, digest handshake or error); a negedge monitor consumes it.
module tb_sha_round_ctrl;
  localparam int RND_W = 7;

  logic             clk = 1'b0, rst = 1'b1;
  logic [2:0]       mode = 3'd0;
  logic             blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0;
  logic             w_valid = 1'b0, hash_ready = 1'b0;
  logic             blk_ready, w_ready, load_state, load_init, enable, update_hash, hash_valid, err;
  logic [RND_W-1:0] round;
  logic [1:0]       ft;

  sha_round_ctrl #(.RND_W(RND_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_first(blk_first), .blk_last(blk_last), .w_valid(w_valid), .w_ready(w_ready),
    .round(round), .ft(ft), .load_state(load_state), .load_init(load_init), .enable(enable),
    .update_hash(update_hash), .hash_valid(hash_valid), .hash_ready(hash_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_LOAD, EV_RND, EV_UPD, EV_HASH, EV_ERR} ev_k;
  typedef struct {ev_k k; int v; int f;} ev_t;
  ev_t q[$];

  int checks = 0, failures = 0, cyc = 0;
  int wv_mode = 0;  // 0: always valid, 1: random, 2: stall 5 cycles at round 10
  int stall_cnt = 0, hr_delay = 0, hr_wait = 0;
  int t_load = -1, t_upd = -1, t_hv = -1, n_upd = 0, n_hv = 0, n_en = 0, n_stall = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic push(input ev_k k, input int v, input int f);
    ev_t e;
    e.k = k; e.v = v; e.f = f;
    q.push_back(e);
  endtask

  task automatic expect_ev(input ev_k k, input int v, input int f, input string nm);
    ev_t e;
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s unexpected event actual=%0d required=none", nm, v);
      return;
    end
    e = q.pop_front();
    chk({nm, " kind"}, int'(k), int'(e.k));
    if (k == e.k) begin
      chk({nm, " value"}, v, e.v);
      if (k == EV_RND) chk("ft", f, e.f);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (load_state) begin t_load = cyc; expect_ev(EV_LOAD, int'(load_init), 0, "load"); end
      if (enable) begin n_en++; expect_ev(EV_RND, int'(round), int'(ft), "round"); end
      if (!enable && round == RND_W'(10)) n_stall++;
      if (update_hash) begin t_upd = cyc; n_upd++; expect_ev(EV_UPD, 0, 0, "update"); end
      if (err) expect_ev(EV_ERR, 0, 0, "err");
      if (hash_valid) begin
        n_hv++;
        if (t_hv < 0) t_hv = cyc;
        if (hash_ready) expect_ev(EV_HASH, 0, 0, "hash");
      end
    end
  end

  // schedule-word source
  always @(posedge clk) begin
    #1;
    case (wv_mode)
      0: w_valid = 1'b1;
      1: w_valid = ($urandom_range(0, 3) != 0);
      default: begin
        if (round == RND_W'(10) && stall_cnt < 5) begin w_valid = 1'b0; stall_cnt++; end
        else w_valid = 1'b1;
      end
    endcase
  end

  // digest consumer: accepts after hash_valid has been up hr_delay+1 cycles
  always @(posedge clk) begin
    #1;
    if (hash_valid) hr_wait++; else hr_wait = 0;
    hash_ready = hash_valid && (hr_wait > hr_delay);
  end

  task automatic send_block(input logic [2:0] m, input bit f, input bit l, output int acc);
    int guard = 0;
    int n;
    @(posedge clk); #1;
    mode = m; blk_first = f; blk_last = l; blk_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (blk_ready) break;
      guard++;
      if (guard > 3000) begin
        checks++; failures++;
        $display("FAIL accept timeout actual=%0d required=<3000", guard);
        break;
      end
    end
    acc = cyc;
    if (m == 3'd7) push(EV_ERR, 0, 0);
    else begin
      n = (m == 3'd1 || m == 3'd2) ? 64 : 80;
      push(EV_LOAD, int'(f), 0);
      for (int r = 0; r < n; r++) push(EV_RND, r, (m == 3'd0) ? r / 20 : 0);
      push(EV_UPD, 0, 0);
      if (l) push(EV_HASH, 0, 0);
    end
    @(posedge clk); #1;
    blk_valid = 1'b0;
    mode = 3'($urandom); blk_first = 1'($urandom); blk_last = 1'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 4000) begin @(negedge clk); guard++; end
    chk("drain remaining", q.size(), 0);
  endtask

  task automatic clr();
    t_load = -1; t_upd = -1; t_hv = -1; n_upd = 0; n_hv = 0; n_en = 0; n_stall = 0;
  endtask

  initial begin
    int acc, acc2, nb, upd0, guard;
    logic [2:0] m;
    // reset state
    @(negedge clk);
    chk("outputs under reset",
        int'({blk_ready, w_ready, round, ft, load_state, load_init, enable, update_hash, hash_valid, err}), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle blk_ready", int'(blk_ready), 1);
    chk("idle round", int'(round), 0);
    chk("idle hash_valid", int'(hash_valid), 0);

    // sha256 single block, no stall, digest held 4 cycles
    clr(); wv_mode = 0; hr_delay = 3;
    send_block(3'd2, 1'b1, 1'b1, acc);
    drain();
    chk("sha256 load cycle", t_load - acc, 1);
    chk("sha256 enables", n_en, 64);
    chk("sha256 update cycle", t_upd - acc, 66);
    chk("sha256 hash_valid cycle", t_hv - acc, 67);
    chk("sha256 hash_valid length", n_hv, 4);

    // sha1 single block: ft checked per round by the scoreboard
    clr(); hr_delay = 0;
    send_block(3'd0, 1'b1, 1'b1, acc);
    drain();
    chk("sha1 enables", n_en, 80);
    chk("sha1 update cycle", t_upd - acc, 82);

    // sha256 with a 5-cycle schedule stall at round 10
    clr(); wv_mode = 2; stall_cnt = 0;
    send_block(3'd2, 1'b1, 1'b1, acc);
    drain();
    chk("stall cycles at round 10", n_stall, 5);
    chk("stall update cycle", t_upd - acc, 71);
    wv_mode = 0;

    // sha512 two-block message, back-to-back
    clr();
    send_block(3'd4, 1'b1, 1'b0, acc);
    send_block(3'd4, 1'b0, 1'b1, acc2);
    drain();
    chk("back-to-back accept", acc2 - acc, 83);
    chk("two-block updates", n_upd, 2);
    chk("two-block enables", n_en, 160);
    chk("two-block hash_valid cycle", t_hv - acc2, 83);

    // reset at round 30
    clr();
    send_block(3'd2, 1'b1, 1'b1, acc);
    guard = 0;
    while (round != RND_W'(30) && guard < 200) begin @(posedge clk); #1; guard++; end
    chk("reached round 30", int'(round), 30);
    rst = 1'b1;
    @(negedge clk);
    chk("outputs under mid reset", int'({blk_ready, enable, update_hash, round}), 0);
    @(posedge clk); #1;
    rst = 1'b0; q.delete(); upd0 = n_upd;
    @(negedge clk);
    chk("post-reset blk_ready", int'(blk_ready), 1);
    chk("post-reset round", int'(round), 0);
    repeat (100) @(negedge clk);
    chk("post-reset no update", n_upd - upd0, 0);
    chk("post-reset no hash_valid", n_hv, 0);

    // unsupported mode
    clr();
    send_block(3'd7, 1'b1, 1'b1, acc);
    @(negedge clk);
    chk("mode7 err", int'(err), 1);
    chk("mode7 blk_ready", int'(blk_ready), 1);
    chk("mode7 load_state", int'(load_state), 0);
    @(negedge clk);
    chk("mode7 err one cycle", int'(err), 0);

    // random messages
    wv_mode = 1;
    for (int i = 0; i < 30; i++) begin
      nb = $urandom_range(1, 3);
      hr_delay = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        m = ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        send_block(m, b == 0, b == nb - 1, acc);
      end
    end
    drain();
    repeat (5) @(negedge clk);
    chk("final queue empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
